// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A grant lasts until the packet ends, the burst cap is reached, or the owner drops req.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_W     = 2,
   parameter int unsigned BURST_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        accept,
   output logic                      fifo_wr,
   output logic [DATA_W-1:0]         fifo_data,
   input  logic                      stack_full,
   output logic [IDX_W-1:0]          owner,
   output logic                      busy
);

   localparam logic [3:0] BurstLast = 4'(BURST_MAX - 1);

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic [IDX_W-1:0] last_owner_q;

   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand_idx;
   logic [31:0]      cand;
   logic             release_now;

   // Circular search starting one past the previous owner.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand     = (32'(last_owner_q) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!pick_valid && req[cand_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Write strobe depends only on registered state and control inputs, never on data.
   always_comb begin
      accept = '0;
      if (state_q == StXfer && gnt[owner] && req[owner] && !stack_full) begin
         accept[owner] = 1'b1;
      end
   end

   assign fifo_wr   = |accept;
   assign fifo_data = req_data[32'(owner) * DATA_W +: DATA_W];

   assign release_now = !req[owner] ||
                        (fifo_wr && (req_last[owner] || cnt_q == BurstLast));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         gnt          <= '0;
         owner        <= '0;
         busy         <= 1'b0;
         cnt_q        <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  gnt     <= NUM_REQ'(1) << pick_idx;
                  owner   <= pick_idx;
                  busy    <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= StXfer;
               end
            end
            StXfer: begin
               if (release_now) begin
                  last_owner_q <= owner;
                  gnt          <= '0;
                  busy         <= 1'b0;
                  cnt_q        <= '0;
                  state_q      <= StIdle;
               end else if (fifo_wr) begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
